ctrl_decode_stage: RTL and testbench
====================================

# ctrl_decode_stage

Registered, handshaked successor to the combinational control unit: decodes one 4-bit opcode per accepted beat into the full control-word bundle and holds it in an output register for the execute stage. Adds valid/ready flow control, a jump-squash window of parametrised depth, a halt state entered on end-of-program, and a retired-instruction counter. It sits between fetch and execute in the pipelined processor.

## Interface
- FLUSH_DEPTH, 2, number of accepted beats squashed after a jump (0 = no squash)
- CNT_W, 16, width of retired-instruction counter
- RADDR_W, 3, register-address width (used only with the hazard feature)
- clk  input  1  rising-edge clock; the block's only clock
- rst_n  input  1  asynchronous reset, active-low
- in_valid / in_ready  input / output  1 / 1  fetch-side handshake
- op  input  4  opcode; ctrl  input  1  dual/immediate qualifier; re_config  input  2  register-write config
- in_rs1, in_rs2, in_rd  input  RADDR_W each  source/destination registers
- out_valid / out_ready  output / input  1 / 1  execute-side handshake
- jmp, eop, ctrl_sel, mem_wr, wr_bk_sel  output  1 each  registered control bits
- reg_wr  output  2; alu_sel  output  4; dir_val  output  2  registered control fields
- flush  output  1  high while in FLUSH; halted  output  1  high in HALT after EOP retires
- retired_cnt  output  CNT_W  count of retired non-NOP instructions

## Operation
- Opcode map: 1000 move, 1001 immediate, 1010 load, 1011 store, 1100 shift, 1101 jump, 1110 NOP, 1111 EOP.
- Decode (registered on accept): k = store|jump|NOP|EOP; reg_wr = (re_config | {2{op==1000}}) & ~{2{k}}; mem_wr = store; wr_bk_sel = load; ctrl_sel = ctrl & ~NOP; jmp = jump; eop = EOP; dir_val = {op==1001 & ctrl, op==1100}; alu_sel = op, except NOP gives 0110.
- FSM states RUN, FLUSH, HALT; reset state RUN.
- RUN: in_ready = (~out_valid | out_ready) & ~hazard. Accepted beat loads output register, out_valid=1. Accepted jump -> FLUSH with squash counter = FLUSH_DEPTH (stay RUN if 0). Accepted EOP -> HALT.
- FLUSH: in_ready=1; accepted beats are discarded (no output load, not counted); counter decrements per accepted beat; at 1->0 transition return to RUN. Jump/EOP arriving in FLUSH are discarded.
- HALT: in_ready=0; halted=1 once the EOP beat has handshaken out. Exit only via reset.
- Output register holds stable while out_valid & ~out_ready; cleared (out_valid=0) on handshake unless reloaded the same cycle.
- retired_cnt += 1 on each out handshake whose alu_sel-source op is not NOP; wraps modulo 2^CNT_W.
- Reset mid-operation: all state, counter and outputs cleared immediately, regardless of handshake.

## Timing
- Reset values: out_valid, all control outputs, flush, halted, retired_cnt = 0; state RUN; in_ready = 1 after reset release.
- Latency: accept at edge N -> out_valid and control word visible after edge N; one beat per cycle sustained when out_ready=1.
- Simultaneous out handshake and new accept: new word replaces old, out_valid stays 1.
- flush is registered state, asserted the cycle after the jump is accepted.

## Configuration
- CU_LOAD_USE_STALL_EN defined: hazard = out_valid & wr_bk_sel(reg) & (reg_wr≠0) & (in_rd(reg)==in_rs1 | in_rd(reg)==in_rs2); stalls in_ready for exactly one cycle, output register drains and out_valid drops for that bubble.
- Undefined: hazard tied 0; in_rs1/in_rs2/in_rd ignored.

## Test plan
- Reset then op=1000, re_config=00, out_ready=1 -> next cycle out_valid=1, reg_wr=11, alu_sel=1000; retired_cnt=1 after handshake.
- op=1110 (NOP), ctrl=1 -> ctrl_sel=0, alu_sel=0110, reg_wr=00; retired_cnt unchanged.
- op=1101 then three beats, FLUSH_DEPTH=2 -> jmp=1 out; flush=1 for 2 beats, both discarded; third beat decoded.
- op=1111 with out_ready=0 for 3 cycles -> eop held, in_ready=0, halted=0; out_ready=1 -> halted=1 next cycle, stays until rst_n=0.
- out_ready=0 with out_valid=1 -> in_ready=0, outputs stable; rst_n pulsed low mid-stall -> all outputs 0 immediately.
- CU_LOAD_USE_STALL_EN: load rd=3 then instruction rs1=3 -> one-cycle in_ready=0 bubble, then accepted; without macro accepted back-to-back.

Source files
------------

// File: rtl/ctrl_decode_stage.sv
// ============================================================================
// Module   : ctrl_decode_stage
// Purpose  : Registered, handshaked control decode stage between fetch and
//            execute. Decodes one 4-bit opcode per accepted beat into a
//            control word, holds it in an output register, squashes a
//            programmable number of beats after a jump, halts after
//            end-of-program and counts retired non-NOP instructions.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   FLUSH_DEPTH : beats discarded after an accepted jump (0 = no squash)
//   CNT_W       : retired-instruction counter width
//   RADDR_W     : register address width (load-use hazard option only)
// Ports
//   clk, rst_n               : clock, asynchronous active-low reset
//   i_in_valid / o_in_ready  : fetch-side handshake
//   i_op, i_ctrl, i_re_config: opcode, dual/immediate qualifier, write config
//   i_in_rs1/i_in_rs2/i_in_rd: source / destination register addresses
//   o_out_valid / i_out_ready: execute-side handshake
//   o_jmp, o_eop, o_ctrl_sel, o_mem_wr, o_wr_bk_sel, o_reg_wr, o_alu_sel,
//   o_dir_val                : registered control word
//   o_flush                  : high while squashing after a jump
//   o_halted                 : high once the EOP word has left the stage
//   o_retired_cnt            : retired non-NOP instruction count (wraps)
// Build option
//   CU_LOAD_USE_STALL_EN : when defined, stall one cycle on a load-use
//                          dependency between the held load and the
//                          incoming instruction.
// ============================================================================
`default_nettype none

module ctrl_decode_stage #(
  parameter int FLUSH_DEPTH = 2,
  parameter int CNT_W       = 16,
  parameter int RADDR_W     = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_in_valid,
  output logic               o_in_ready,
  input  logic [3:0]         i_op,
  input  logic               i_ctrl,
  input  logic [1:0]         i_re_config,
  input  logic [RADDR_W-1:0] i_in_rs1,
  input  logic [RADDR_W-1:0] i_in_rs2,
  input  logic [RADDR_W-1:0] i_in_rd,
  output logic               o_out_valid,
  input  logic               i_out_ready,
  output logic               o_jmp,
  output logic               o_eop,
  output logic               o_ctrl_sel,
  output logic               o_mem_wr,
  output logic               o_wr_bk_sel,
  output logic [1:0]         o_reg_wr,
  output logic [3:0]         o_alu_sel,
  output logic [1:0]         o_dir_val,
  output logic               o_flush,
  output logic               o_halted,
  output logic [CNT_W-1:0]   o_retired_cnt
);

  localparam logic [1:0] S_RUN   = 2'd0;
  localparam logic [1:0] S_FLUSH = 2'd1;
  localparam logic [1:0] S_HALT  = 2'd2;

  localparam int              SQ_W    = (FLUSH_DEPTH < 1) ? 1 : $clog2(FLUSH_DEPTH + 1);
  localparam logic [SQ_W-1:0] SQ_INIT = SQ_W'(FLUSH_DEPTH);
  localparam logic [SQ_W-1:0] SQ_ONE  = SQ_W'(1);
  localparam bit              SQ_EN   = (FLUSH_DEPTH != 0);

  // --------------------------------------------------------------------------
  // Opcode decode
  // --------------------------------------------------------------------------
  logic w_is_move, w_is_imm, w_is_load, w_is_store;
  logic w_is_shift, w_is_jump, w_is_nop, w_is_eop, w_no_wr;
  logic [1:0] w_reg_wr;
  logic [3:0] w_alu_sel;
  logic [1:0] w_dir_val;

  assign w_is_move  = (i_op == 4'b1000);
  assign w_is_imm   = (i_op == 4'b1001);
  assign w_is_load  = (i_op == 4'b1010);
  assign w_is_store = (i_op == 4'b1011);
  assign w_is_shift = (i_op == 4'b1100);
  assign w_is_jump  = (i_op == 4'b1101);
  assign w_is_nop   = (i_op == 4'b1110);
  assign w_is_eop   = (i_op == 4'b1111);

  // Opcodes that never write the register file override the write config.
  assign w_no_wr   = w_is_store | w_is_jump | w_is_nop | w_is_eop;
  assign w_reg_wr  = (i_re_config | {2{w_is_move}}) & ~{2{w_no_wr}};
  assign w_alu_sel = w_is_nop ? 4'b0110 : i_op;
  assign w_dir_val = {w_is_imm & i_ctrl, w_is_shift};

  // --------------------------------------------------------------------------
  // Output-register state
  // --------------------------------------------------------------------------
  logic             r_out_valid;
  logic             r_jmp, r_eop, r_ctrl_sel, r_mem_wr, r_wr_bk_sel;
  logic [1:0]       r_reg_wr;
  logic [3:0]       r_alu_sel;
  logic [1:0]       r_dir_val;
  logic             r_is_nop;
  logic             r_halted;
  logic [CNT_W-1:0] r_retired_cnt;

  logic [1:0]      r_state, w_state_nxt;
  logic [SQ_W-1:0] r_sq, w_sq_nxt;

  logic w_hazard, w_accept, w_load, w_out_hs;

  assign w_accept = i_in_valid & o_in_ready;
  assign w_load   = w_accept & (r_state == S_RUN);
  assign w_out_hs = r_out_valid & i_out_ready;

  // --------------------------------------------------------------------------
  // Load-use hazard
  // --------------------------------------------------------------------------
`ifdef CU_LOAD_USE_STALL_EN
  logic [RADDR_W-1:0] r_rd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd <= '0;
    end else if (w_load) begin
      r_rd <= i_in_rd;
    end
  end

  // The held load's result is not yet available; holding off for the one
  // cycle it takes the load to drain breaks the dependency.
  assign w_hazard = r_out_valid & r_wr_bk_sel & (r_reg_wr != 2'b00) &
                    ((r_rd == i_in_rs1) | (r_rd == i_in_rs2));
`else
  logic w_unused_regs;
  assign w_unused_regs = ^{i_in_rs1, i_in_rs2, i_in_rd};
  assign w_hazard      = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_RUN;
      r_sq    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_sq    <= w_sq_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_sq_nxt    = r_sq;
    case (r_state)
      S_RUN: begin
        if (w_accept) begin
          if (w_is_jump && SQ_EN) begin
            w_state_nxt = S_FLUSH;
            w_sq_nxt    = SQ_INIT;
          end else if (w_is_eop) begin
            w_state_nxt = S_HALT;
          end
        end
      end
      S_FLUSH: begin
        // Every accepted beat is squashed, jumps and EOPs included.
        if (w_accept) begin
          w_sq_nxt = r_sq - SQ_ONE;
          if (r_sq == SQ_ONE) begin
            w_state_nxt = S_RUN;
          end
        end
      end
      S_HALT: begin
        w_state_nxt = S_HALT;
      end
      default: begin
        w_state_nxt = S_RUN;
        w_sq_nxt    = '0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: output logic
  // --------------------------------------------------------------------------
  always_comb begin
    o_in_ready = 1'b0;
    o_flush    = 1'b0;
    case (r_state)
      S_RUN:   o_in_ready = (~r_out_valid | i_out_ready) & ~w_hazard;
      S_FLUSH: begin
        o_in_ready = 1'b1;
        o_flush    = 1'b1;
      end
      default: o_in_ready = 1'b0;
    endcase
  end

  // --------------------------------------------------------------------------
  // Output register: reload wins over drain so back-to-back beats keep
  // out_valid asserted.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_jmp       <= 1'b0;
      r_eop       <= 1'b0;
      r_ctrl_sel  <= 1'b0;
      r_mem_wr    <= 1'b0;
      r_wr_bk_sel <= 1'b0;
      r_reg_wr    <= 2'b00;
      r_alu_sel   <= 4'b0000;
      r_dir_val   <= 2'b00;
      r_is_nop    <= 1'b0;
    end else if (w_load) begin
      r_out_valid <= 1'b1;
      r_jmp       <= w_is_jump;
      r_eop       <= w_is_eop;
      r_ctrl_sel  <= i_ctrl & ~w_is_nop;
      r_mem_wr    <= w_is_store;
      r_wr_bk_sel <= w_is_load;
      r_reg_wr    <= w_reg_wr;
      r_alu_sel   <= w_alu_sel;
      r_dir_val   <= w_dir_val;
      r_is_nop    <= w_is_nop;
    end else if (w_out_hs) begin
      r_out_valid <= 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // Retired counter and halt flag
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_retired_cnt <= '0;
      r_halted      <= 1'b0;
    end else begin
      if (w_out_hs && !r_is_nop) begin
        r_retired_cnt <= r_retired_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      // In HALT the only word that can still be held is the EOP itself.
      if (r_state == S_HALT && w_out_hs) begin
        r_halted <= 1'b1;
      end
    end
  end

  assign o_out_valid   = r_out_valid;
  assign o_jmp         = r_jmp;
  assign o_eop         = r_eop;
  assign o_ctrl_sel    = r_ctrl_sel;
  assign o_mem_wr      = r_mem_wr;
  assign o_wr_bk_sel   = r_wr_bk_sel;
  assign o_reg_wr      = r_reg_wr;
  assign o_alu_sel     = r_alu_sel;
  assign o_dir_val     = r_dir_val;
  assign o_halted      = r_halted;
  assign o_retired_cnt = r_retired_cnt;

endmodule

`default_nettype wire

// File: tb/tb_ctrl_decode_stage.sv
`default_nettype none

module tb_ctrl_decode_stage;

  localparam int RW = 3;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid, in_ready;
  logic [3:0]    op;
  logic          ctrl;
  logic [1:0]    re_config;
  logic [RW-1:0] rs1, rs2, rd;
  logic          out_valid, out_ready;
  logic          jmp, eop, ctrl_sel, mem_wr, wr_bk_sel;
  logic [1:0]    reg_wr;
  logic [3:0]    alu_sel;
  logic [1:0]    dir_val;
  logic          flush, halted;
  logic [CW-1:0] retired_cnt;

  always #5 clk = ~clk;

  ctrl_decode_stage #(.FLUSH_DEPTH(2), .CNT_W(CW), .RADDR_W(RW)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_in_valid(in_valid), .o_in_ready(in_ready),
    .i_op(op), .i_ctrl(ctrl), .i_re_config(re_config),
    .i_in_rs1(rs1), .i_in_rs2(rs2), .i_in_rd(rd),
    .o_out_valid(out_valid), .i_out_ready(out_ready),
    .o_jmp(jmp), .o_eop(eop), .o_ctrl_sel(ctrl_sel), .o_mem_wr(mem_wr),
    .o_wr_bk_sel(wr_bk_sel), .o_reg_wr(reg_wr), .o_alu_sel(alu_sel),
    .o_dir_val(dir_val), .o_flush(flush), .o_halted(halted),
    .o_retired_cnt(retired_cnt)
  );

  int checks = 0;
  int errors = 0;
  int exp_cnt = 0;

  // Word layout: {reg_wr, alu_sel, ctrl_sel, mem_wr, wr_bk_sel, dir_val, jmp, eop}
  typedef struct {
    logic [3:0]  op;
    logic        ctrl;
    logic [1:0]  rc;
    logic [12:0] exp;
  } vec_t;

  vec_t tbl [8];

  function automatic logic [12:0] word();
    return {reg_wr, alu_sel, ctrl_sel, mem_wr, wr_bk_sel, dir_val, jmp, eop};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] o, input logic c, input logic [1:0] r);
    in_valid  = 1'b1;
    op        = o;
    ctrl      = c;
    re_config = r;
  endtask

  initial begin
    tbl[0] = '{4'b1000, 1'b0, 2'b00, {2'b11, 4'b1000, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0}};
    tbl[1] = '{4'b1001, 1'b1, 2'b10, {2'b10, 4'b1001, 1'b1, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0}};
    tbl[2] = '{4'b1001, 1'b0, 2'b01, {2'b01, 4'b1001, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0}};
    tbl[3] = '{4'b1010, 1'b0, 2'b01, {2'b01, 4'b1010, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0}};
    tbl[4] = '{4'b1011, 1'b1, 2'b11, {2'b00, 4'b1011, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0}};
    tbl[5] = '{4'b1100, 1'b1, 2'b11, {2'b11, 4'b1100, 1'b1, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0}};
    tbl[6] = '{4'b1110, 1'b1, 2'b11, {2'b00, 4'b0110, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0}};
    tbl[7] = '{4'b0011, 1'b0, 2'b10, {2'b10, 4'b0011, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0}};

    rst_n = 1'b0; in_valid = 1'b0; op = 4'h0; ctrl = 1'b0; re_config = 2'b00;
    rs1 = '0; rs2 = '0; rd = '0; out_ready = 1'b1;

    // Reset state
    #12;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_word", {19'd0, word()}, 32'd0);
    chk("rst_cnt", {16'd0, retired_cnt}, 32'd0);
    chk("rst_flush_halt", {30'd0, flush, halted}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    tick();

    // Table-driven single beats
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("v%0d_cnt_before", i), {16'd0, retired_cnt}, exp_cnt);
      chk($sformatf("v%0d_in_ready", i), {31'd0, in_ready}, 32'd1);
      drive(tbl[i].op, tbl[i].ctrl, tbl[i].rc);
      tick();
      chk($sformatf("v%0d_valid", i), {31'd0, out_valid}, 32'd1);
      chk($sformatf("v%0d_word", i), {19'd0, word()}, {19'd0, tbl[i].exp});
      in_valid = 1'b0;
      tick();
      if (tbl[i].op != 4'b1110) exp_cnt++;
      chk($sformatf("v%0d_drained", i), {31'd0, out_valid}, 32'd0);
    end
    chk("table_cnt", {16'd0, retired_cnt}, exp_cnt);

    // Back-to-back beats with out_ready=1
    drive(4'b1000, 1'b0, 2'b00);
    tick();
    drive(4'b1100, 1'b0, 2'b00);
    chk("b2b_in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    exp_cnt++;
    chk("b2b_valid", {31'd0, out_valid}, 32'd1);
    chk("b2b_alu", {28'd0, alu_sel}, 32'h0000000C);
    in_valid = 1'b0;
    tick();
    exp_cnt++;
    chk("b2b_cnt", {16'd0, retired_cnt}, exp_cnt);

    // Jump then three beats: two squashed, third decoded
    drive(4'b1101, 1'b0, 2'b11);
    tick();
    chk("jmp_out", {31'd0, jmp}, 32'd1);
    chk("jmp_flush", {31'd0, flush}, 32'd1);
    chk("jmp_reg_wr", {30'd0, reg_wr}, 32'd0);
    drive(4'b1000, 1'b0, 2'b00);
    tick();
    exp_cnt++;
    chk("sq1_valid", {31'd0, out_valid}, 32'd0);
    chk("sq1_flush", {31'd0, flush}, 32'd1);
    drive(4'b1001, 1'b1, 2'b01);
    tick();
    chk("sq2_valid", {31'd0, out_valid}, 32'd0);
    chk("sq2_flush", {31'd0, flush}, 32'd0);
    chk("sq_cnt", {16'd0, retired_cnt}, exp_cnt);
    drive(4'b1100, 1'b0, 2'b00);
    tick();
    chk("post_jmp_valid", {31'd0, out_valid}, 32'd1);
    chk("post_jmp_word", {19'd0, word()},
        {19'd0, 2'b00, 4'b1100, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0});
    in_valid = 1'b0;
    tick();
    exp_cnt++;
    chk("post_jmp_cnt", {16'd0, retired_cnt}, exp_cnt);

    // Stall with out_ready=0, then reset mid-stall
    out_ready = 1'b0;
    drive(4'b1000, 1'b0, 2'b00);
    tick();
    chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
    drive(4'b1100, 1'b1, 2'b11);
    tick();
    tick();
    chk("stall_valid", {31'd0, out_valid}, 32'd1);
    chk("stall_word", {19'd0, word()},
        {19'd0, 2'b11, 4'b1000, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0});
    chk("stall_in_ready2", {31'd0, in_ready}, 32'd0);
    rst_n = 1'b0;
    #2;
    exp_cnt = 0;
    chk("midrst_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_word", {19'd0, word()}, 32'd0);
    chk("midrst_cnt", {16'd0, retired_cnt}, 32'd0);
    in_valid = 1'b0;
    out_ready = 1'b1;
    #2;
    rst_n = 1'b1;
    tick();

    // Load followed by a dependent instruction
    rs1 = 3'd0; rs2 = 3'd0; rd = 3'd3;
    drive(4'b1010, 1'b0, 2'b01);
    tick();
    chk("ld_wr_bk", {31'd0, wr_bk_sel}, 32'd1);
    rs1 = 3'd3; rs2 = 3'd1; rd = 3'd5;
    drive(4'b1000, 1'b0, 2'b00);
`ifdef CU_LOAD_USE_STALL_EN
    #1;
    chk("haz_bubble", {31'd0, in_ready}, 32'd0);
    tick();
    exp_cnt++;
    chk("haz_drain", {31'd0, out_valid}, 32'd0);
    chk("haz_ready", {31'd0, in_ready}, 32'd1);
    tick();
`else
    #1;
    chk("nohaz_ready", {31'd0, in_ready}, 32'd1);
    tick();
    exp_cnt++;
`endif
    chk("dep_valid", {31'd0, out_valid}, 32'd1);
    chk("dep_alu", {28'd0, alu_sel}, 32'h00000008);
    in_valid = 1'b0;
    tick();
    exp_cnt++;
    chk("dep_cnt", {16'd0, retired_cnt}, exp_cnt);

    // EOP held for three cycles, then retired into HALT
    out_ready = 1'b0;
    drive(4'b1111, 1'b1, 2'b11);
    tick();
    in_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("eop_hold%0d_word", c), {19'd0, word()},
          {19'd0, 2'b00, 4'b1111, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1});
      chk($sformatf("eop_hold%0d_rdy_halt", c), {30'd0, in_ready, halted}, 32'd0);
      tick();
    end
    out_ready = 1'b1;
    tick();
    exp_cnt++;
    chk("halted", {31'd0, halted}, 32'd1);
    chk("halt_valid", {31'd0, out_valid}, 32'd0);
    chk("halt_cnt", {16'd0, retired_cnt}, exp_cnt);
    drive(4'b1000, 1'b0, 2'b00);
    #1;
    chk("halt_in_ready", {31'd0, in_ready}, 32'd0);
    tick();
    tick();
    chk("halt_no_accept", {30'd0, out_valid, halted}, 32'd1);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #2;
    chk("halt_rst", {30'd0, halted, out_valid}, 32'd0);
    rst_n = 1'b1;
    #2;
    chk("halt_rst_ready", {31'd0, in_ready}, 32'd1);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
